// File: rtl/ifu_responder.sv
`default_nettype none
// ============================================================================
// Module   : ifu_responder
// Desc     : Fetch-stage read responder: checks word alignment and runs one
//            OCP-style bus read (cmd/accept/resp) per aligned fetch.
//            Define IFU_LAST_HIT_EN to add a last-address hit buffer.
// Revision : 1.0  initial release
// ============================================================================
module ifu_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_rd_cmd,
    output logic [DATA_WIDTH-1:0] o_instr_dat,
    output logic                  o_busy,
    output logic                  o_err_align,
    output logic                  o_err_bus,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic                  o_bus_cmd,
    input  logic                  i_bus_accept,
    input  logic [DATA_WIDTH-1:0] i_bus_data,
    input  logic [1:0]            i_bus_resp
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_DVA  = 2'b01;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] instr_dat;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic                  bus_cmd;
    logic                  err_align;
    logic                  err_bus;
    logic                  misaligned;
    logic                  hit;

    assign misaligned = (i_addr[1:0] != 2'b00);

`ifdef IFU_LAST_HIT_EN
    logic                  hit_valid;
    logic [ADDR_WIDTH-1:0] hit_tag;

    assign hit = hit_valid && (i_addr == hit_tag);

    // The tag tracks the address of the last good (DVA) response only.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            hit_valid <= 1'b0;
            hit_tag   <= '0;
        end else if (state == RESP && i_bus_resp != RESP_NULL) begin
            if (i_bus_resp == RESP_DVA) begin
                hit_valid <= 1'b1;
                hit_tag   <= bus_addr;
            end else begin
                hit_valid <= 1'b0;
            end
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= IDLE;
            instr_dat <= '0;
            bus_addr  <= '0;
            bus_cmd   <= 1'b0;
            err_align <= 1'b0;
            err_bus   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_rd_cmd) begin
                        err_align <= misaligned;
                        err_bus   <= 1'b0;
                        if (!misaligned && !hit) begin
                            bus_addr <= i_addr;
                            bus_cmd  <= 1'b1;
                            state    <= CMD;
                        end
                    end
                end
                CMD: begin
                    // Any response arriving alongside accept is deliberately dropped.
                    if (i_bus_accept) begin
                        bus_cmd <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (i_bus_resp == RESP_DVA) begin
                        instr_dat <= i_bus_data;
                        state     <= IDLE;
                    end else if (i_bus_resp != RESP_NULL) begin
                        instr_dat <= '0;
                        err_bus   <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bus_cmd <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy      = (state != IDLE);
    assign o_instr_dat = instr_dat;
    assign o_err_align = err_align;
    assign o_err_bus   = err_bus;
    assign o_bus_addr  = bus_addr;
    assign o_bus_cmd   = bus_cmd;

endmodule
`default_nettype wire

// File: tb/tb_ifu_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_responder
// Desc     : Self-checking bench for ifu_responder: directed vector table,
//            last-address-hit sequence and randomized run against a
//            transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ifu_responder;

    logic        clk;
    logic        nrst;
    logic [31:0] addr;
    logic        rd_cmd;
    logic [31:0] instr_dat;
    logic        busy;
    logic        err_align;
    logic        err_bus;
    logic [31:0] bus_addr;
    logic        bus_cmd;
    logic        bus_accept;
    logic [31:0] bus_data;
    logic [1:0]  bus_resp;

    int errors = 0;
    int checks = 0;

    ifu_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .i_addr       (addr),
        .i_rd_cmd     (rd_cmd),
        .o_instr_dat  (instr_dat),
        .o_busy       (busy),
        .o_err_align  (err_align),
        .o_err_bus    (err_bus),
        .o_bus_addr   (bus_addr),
        .o_bus_cmd    (bus_cmd),
        .i_bus_accept (bus_accept),
        .i_bus_data   (bus_data),
        .i_bus_resp   (bus_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        nrst;
        logic        rd;
        logic [31:0] addr;
        logic        acc;
        logic [1:0]  resp;
        logic [31:0] data;
        logic        e_busy;
        logic        e_cmd;
        logic        e_ea;
        logic        e_eb;
        logic [31:0] e_instr;
        logic [31:0] e_baddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic n, logic r, logic [31:0] a, logic ac, logic [1:0] rs,
                                logic [31:0] d, logic eb_, logic ec, logic eea, logic eeb,
                                logic [31:0] ei, logic [31:0] eba);
        vec_t v;
        v.nrst = n; v.rd = r; v.addr = a; v.acc = ac; v.resp = rs; v.data = d;
        v.e_busy = eb_; v.e_cmd = ec; v.e_ea = eea; v.e_eb = eeb;
        v.e_instr = ei; v.e_baddr = eba;
        return v;
    endfunction

    task automatic check_outputs(string name, logic x_busy, logic x_cmd, logic x_ea,
                                 logic x_eb, logic [31:0] x_instr, logic [31:0] x_baddr);
        checks++;
        if (busy !== x_busy || bus_cmd !== x_cmd || err_align !== x_ea ||
            err_bus !== x_eb || instr_dat !== x_instr || bus_addr !== x_baddr) begin
            errors++;
            $display("FAIL %s: got busy=%b cmd=%b ea=%b eb=%b instr=%h baddr=%h, want busy=%b cmd=%b ea=%b eb=%b instr=%h baddr=%h",
                     name, busy, bus_cmd, err_align, err_bus, instr_dat, bus_addr,
                     x_busy, x_cmd, x_ea, x_eb, x_instr, x_baddr);
        end
    endtask

    task automatic check_int(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Drive one cycle of inputs, clock once, look at the outputs 1ns later.
    task automatic cycle(logic n, logic r, logic [31:0] a, logic ac, logic [1:0] rs,
                         logic [31:0] d);
        nrst = n; rd_cmd = r; addr = a; bus_accept = ac; bus_resp = rs; bus_data = d;
        @(posedge clk);
        #1;
    endtask

    // Reference model: one open fetch transaction, tracked as "issued" and
    // "accepted" events, plus the sticky result registers the fetch stage sees.
    bit          m_open, m_accepted, m_hv;
    logic [31:0] m_addr, m_instr, m_tag;
    logic        m_ea, m_eb;

    task automatic model_reset();
        m_open = 0; m_accepted = 0; m_hv = 0;
        m_addr = 0; m_instr = 0; m_tag = 0; m_ea = 0; m_eb = 0;
    endtask

    task automatic model_step(logic n, logic r, logic [31:0] a, logic ac, logic [1:0] rs,
                              logic [31:0] d);
        bit hit_en;
`ifdef IFU_LAST_HIT_EN
        hit_en = 1;
`else
        hit_en = 0;
`endif
        if (!n) begin
            model_reset();
        end else if (!m_open) begin
            if (r) begin
                m_eb = 0;
                m_ea = (a % 4) != 0;
                if (!m_ea && !(hit_en && m_hv && a == m_tag)) begin
                    m_open = 1; m_accepted = 0; m_addr = a;
                end
            end
        end else if (!m_accepted) begin
            if (ac) m_accepted = 1;
        end else if (rs == 2'b01) begin
            m_instr = d; m_open = 0; m_hv = 1; m_tag = m_addr;
        end else if (rs != 2'b00) begin
            m_instr = 0; m_eb = 1; m_open = 0; m_hv = 0;
        end
    endtask

    task automatic fetch_400(output int cmd_cycles, output int busy_cycles);
        cmd_cycles = 0; busy_cycles = 0;
        cycle(1, 1, 32'h400, 1, 2'b01, 32'h3c010040);
        rd_cmd = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus_cmd) cmd_cycles++;
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int c1, b1, c2, b2;
        nrst = 0; rd_cmd = 0; addr = 0; bus_accept = 0; bus_resp = 0; bus_data = 0;

        //            nrst rd addr          acc resp   data          busy cmd ea eb instr         baddr
        vecs.push_back(mk(0, 0, 32'h0,   0, 2'b00, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0));
        // aligned fetch, accept first cycle, DVA next
        vecs.push_back(mk(1, 1, 32'h100, 0, 2'b00, 32'h0,        1, 1, 0, 0, 32'h0,        32'h100));
        vecs.push_back(mk(1, 0, 32'h0,   1, 2'b00, 32'h0,        1, 0, 0, 0, 32'h0,        32'h100));
        vecs.push_back(mk(1, 0, 32'h0,   0, 2'b01, 32'h24020005, 0, 0, 0, 0, 32'h24020005, 32'h100));
        // misaligned fetch, sticky flag, cleared by next fetch
        vecs.push_back(mk(1, 1, 32'h102, 0, 2'b00, 32'h0,        0, 0, 1, 0, 32'h24020005, 32'h100));
        vecs.push_back(mk(1, 0, 32'h0,   0, 2'b00, 32'h0,        0, 0, 1, 0, 32'h24020005, 32'h100));
        vecs.push_back(mk(1, 1, 32'h104, 0, 2'b00, 32'h0,        1, 1, 0, 0, 32'h24020005, 32'h104));
        vecs.push_back(mk(1, 0, 32'h0,   1, 2'b00, 32'h0,        1, 0, 0, 0, 32'h24020005, 32'h104));
        vecs.push_back(mk(1, 0, 32'h0,   0, 2'b00, 32'h0,        1, 0, 0, 0, 32'h24020005, 32'h104));
        vecs.push_back(mk(1, 0, 32'h0,   0, 2'b01, 32'h11111111, 0, 0, 0, 0, 32'h11111111, 32'h104));
        // delayed accept, early and same-cycle responses ignored
        vecs.push_back(mk(1, 1, 32'h200, 0, 2'b00, 32'h0,        1, 1, 0, 0, 32'h11111111, 32'h200));
        vecs.push_back(mk(1, 0, 32'h0,   0, 2'b01, 32'hbad0bad0, 1, 1, 0, 0, 32'h11111111, 32'h200));
        vecs.push_back(mk(1, 0, 32'h0,   0, 2'b00, 32'h0,        1, 1, 0, 0, 32'h11111111, 32'h200));
        vecs.push_back(mk(1, 0, 32'h0,   0, 2'b00, 32'h0,        1, 1, 0, 0, 32'h11111111, 32'h200));
        vecs.push_back(mk(1, 0, 32'h0,   1, 2'b01, 32'h0000dead, 1, 0, 0, 0, 32'h11111111, 32'h200));
        vecs.push_back(mk(1, 0, 32'h0,   0, 2'b01, 32'h22222222, 0, 0, 0, 0, 32'h22222222, 32'h200));
        // reset during RESP, late DVA ignored
        vecs.push_back(mk(1, 1, 32'h500, 0, 2'b00, 32'h0,        1, 1, 0, 0, 32'h22222222, 32'h500));
        vecs.push_back(mk(1, 0, 32'h0,   1, 2'b00, 32'h0,        1, 0, 0, 0, 32'h22222222, 32'h500));
        vecs.push_back(mk(0, 0, 32'h0,   0, 2'b00, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   0, 2'b01, 32'h55555555, 0, 0, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   0, 2'b01, 32'h55555555, 0, 0, 0, 0, 32'h0,        32'h0));
        // ERR response
        vecs.push_back(mk(1, 1, 32'h300, 0, 2'b00, 32'h0,        1, 1, 0, 0, 32'h0,        32'h300));
        vecs.push_back(mk(1, 0, 32'h0,   1, 2'b00, 32'h0,        1, 0, 0, 0, 32'h0,        32'h300));
        vecs.push_back(mk(1, 0, 32'h0,   0, 2'b11, 32'h77777777, 0, 0, 0, 1, 32'h0,        32'h300));
        // new request clears err_bus; request while busy ignored; FAIL response
        vecs.push_back(mk(1, 1, 32'h204, 0, 2'b00, 32'h0,        1, 1, 0, 0, 32'h0,        32'h204));
        vecs.push_back(mk(1, 1, 32'h208, 0, 2'b00, 32'h0,        1, 1, 0, 0, 32'h0,        32'h204));
        vecs.push_back(mk(1, 0, 32'h0,   1, 2'b00, 32'h0,        1, 0, 0, 0, 32'h0,        32'h204));
        vecs.push_back(mk(1, 1, 32'h20a, 0, 2'b10, 32'h66666666, 0, 0, 0, 1, 32'h0,        32'h204));
        // reset clears a sticky error
        vecs.push_back(mk(0, 0, 32'h0,   0, 2'b00, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].nrst, vecs[i].rd, vecs[i].addr, vecs[i].acc, vecs[i].resp, vecs[i].data);
            check_outputs($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_cmd, vecs[i].e_ea,
                          vecs[i].e_eb, vecs[i].e_instr, vecs[i].e_baddr);
        end

        // Two fetches of the same address: hit buffer decides the second one.
        cycle(0, 0, 32'h0, 0, 2'b00, 32'h0);
        fetch_400(c1, b1);
        check_int("hit_first_cmd_cycles", c1, 1);
        check_int("hit_first_busy_cycles", b1, 2);
        fetch_400(c2, b2);
`ifdef IFU_LAST_HIT_EN
        check_int("hit_second_cmd_cycles", c2, 0);
        check_int("hit_second_busy_cycles", b2, 0);
`else
        check_int("hit_second_cmd_cycles", c2, 1);
        check_int("hit_second_busy_cycles", b2, 2);
`endif
        check_outputs("hit_final", 0, 0, 0, 0, 32'h3c010040, 32'h400);

        // Randomized run against the reference model.
        cycle(0, 0, 32'h0, 0, 2'b00, 32'h0);
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        n, r, ac;
            logic [31:0] a, d;
            logic [1:0]  rs;
            n  = ($urandom_range(0, 99) != 0);
            r  = ($urandom_range(0, 2) == 0);
            a  = (32'h1000 + 32'($urandom_range(0, 3)) * 32'h10)
                 | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'h0);
            ac = ($urandom_range(0, 1) == 1);
            rs = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
            d  = $urandom;
            cycle(n, r, a, ac, rs, d);
            model_step(n, r, a, ac, rs, d);
            check_outputs($sformatf("rand%0d", i), m_open, m_open && !m_accepted,
                          m_ea, m_eb, m_instr, m_addr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
